slider_debouncer: RTL and testbench



---
 rtl/slider_debouncer.sv | 140 ++++++++++++++
 tb/tb_slider_debouncer.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/slider_debouncer.sv
// Purpose : synchronise and debounce the DE10-Lite slider switches, one independent filter per bit.
// Latency : raw step sampled at edge k reaches sw_clean at edge k+1+DEBOUNCE_CYCLES; strobes coincide.
// Backpr. : none; free-running conditioning stage, outputs are plain registered levels/pulses.
//
// Ports:
//   clk          system clock (50 MHz domain)
//   reset_n      asynchronous active-low reset, clears every flop immediately
//   sw_raw       raw, asynchronous, bouncing switch pins
//   sw_clean     debounced, synchronised switch state (feeds the sliders PIO in_port)
//   change_mask  one-cycle pulse per bit that updated sw_clean on this edge
//   sw_changed   one-cycle pulse, OR of change_mask
module slider_debouncer #(
  parameter int WIDTH           = 10,
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int CNT_W           = 19
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] sw_raw,
  output logic [WIDTH-1:0] sw_clean,
  output logic [WIDTH-1:0] change_mask,
  output logic             sw_changed
);

  typedef enum logic {
    STABLE  = 1'b0,
    PENDING = 1'b1
  } state_e;

  // Value the counter holds on the cycle before acceptance: the accepting
  // edge is the DEBOUNCE_CYCLES-th consecutive differing sync2 sample.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  // Two-flop synchroniser; only sync2_q is consumed downstream.
  logic [WIDTH-1:0] sync1_q;
  logic [WIDTH-1:0] sync2_q;

  // Per-bit filter state.
  state_e           state_q [WIDTH];
  state_e           state_d [WIDTH];
  logic [CNT_W-1:0] cnt_q   [WIDTH];
  logic [CNT_W-1:0] cnt_d   [WIDTH];

  // Registered outputs.
  logic [WIDTH-1:0] clean_q;
  logic [WIDTH-1:0] clean_d;
  logic [WIDTH-1:0] mask_q;
  logic [WIDTH-1:0] mask_d;
  logic             changed_q;
  logic             changed_d;

  // ------------------------------------------------------------------
  // Synchroniser
  // ------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= sw_raw;
      sync2_q <= sync1_q;
    end
  end

  // ------------------------------------------------------------------
  // Per-bit FSM state and counters
  // ------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < WIDTH; i++) begin
        state_q[i] <= STABLE;
        cnt_q[i]   <= '0;
      end
    end else begin
      for (int i = 0; i < WIDTH; i++) begin
        state_q[i] <= state_d[i];
        cnt_q[i]   <= cnt_d[i];
      end
    end
  end

  // ------------------------------------------------------------------
  // Per-bit next-state logic
  // ------------------------------------------------------------------
  always_comb begin
    clean_d = clean_q;
    mask_d  = '0;
    for (int i = 0; i < WIDTH; i++) begin
      state_d[i] = state_q[i];
      cnt_d[i]   = cnt_q[i];
      case (state_q[i])
        STABLE: begin
          cnt_d[i] = '0;
          if (sync2_q[i] != clean_q[i]) begin
            // First differing sample counts as sample number one.
            state_d[i] = PENDING;
            cnt_d[i]   = CNT_ONE;
          end
        end
        PENDING: begin
          if (sync2_q[i] == clean_q[i]) begin
            // Bounced back before maturing: discard silently.
            state_d[i] = STABLE;
            cnt_d[i]   = '0;
          end else if (cnt_q[i] == CNT_LAST) begin
            state_d[i] = STABLE;
            cnt_d[i]   = '0;
            clean_d[i] = sync2_q[i];
            mask_d[i]  = 1'b1;
          end else begin
            // Bounded by CNT_LAST, so this never wraps.
            cnt_d[i] = cnt_q[i] + CNT_ONE;
          end
        end
      endcase
    end
    changed_d = |mask_d;
  end

  // ------------------------------------------------------------------
  // Output registers
  // ------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      clean_q   <= '0;
      mask_q    <= '0;
      changed_q <= 1'b0;
    end else begin
      clean_q   <= clean_d;
      mask_q    <= mask_d;
      changed_q <= changed_d;
    end
  end

  assign sw_clean    = clean_q;
  assign change_mask = mask_q;
  assign sw_changed  = changed_q;

endmodule

// File: tb/tb_slider_debouncer.sv
// Purpose : self-checking bench for slider_debouncer with a short debounce window.
// Latency : expected pulses are scheduled at absolute edge numbers and checked on the falling edge.
// Backpr. : none; the monitor flags any pulse the stimulus did not schedule.
module tb_slider_debouncer;

  localparam int W = 10;
  localparam int D = 8;

  logic         clk;
  logic         reset_n;
  logic [W-1:0] sw_raw;
  logic [W-1:0] sw_clean;
  logic [W-1:0] change_mask;
  logic         sw_changed;

  slider_debouncer #(
    .WIDTH          (W),
    .DEBOUNCE_CYCLES(D),
    .CNT_W          (19)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .sw_raw     (sw_raw),
    .sw_clean   (sw_clean),
    .change_mask(change_mask),
    .sw_changed (sw_changed)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Number of rising edges seen so far; stable whenever the falling edge is sampled.
  int cyc = 0;
  always @(posedge clk) cyc = cyc + 1;

  typedef struct {
    int           at_edge;
    logic [W-1:0] mask;
    logic [W-1:0] clean;
  } exp_t;

  exp_t exp_q[$];
  int   checks   = 0;
  int   failures = 0;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %h expected %h (edge %0d)", name, act, req, cyc);
    end
  endtask

  // Raw value applied now (falling edge) is first sampled at edge cyc+1,
  // so the filter accepts it at edge cyc+1+1+D.
  task automatic expect_change(input logic [W-1:0] mask, input logic [W-1:0] clean);
    exp_t e;
    e.at_edge = cyc + 2 + D;
    e.mask    = mask;
    e.clean   = clean;
    exp_q.push_back(e);
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Monitor: every pulse must match the head of the scoreboard.
  always @(negedge clk) begin
    if (reset_n && (sw_changed || change_mask != '0)) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_pulse: mask=%h changed=%b clean=%h at edge %0d",
                 change_mask, sw_changed, sw_clean, cyc);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        checks++;
        if (cyc != e.at_edge) begin
          failures++;
          $display("FAIL pulse_edge: pulse at edge %0d expected edge %0d", cyc, e.at_edge);
        end
        check("pulse_mask", change_mask, e.mask);
        check("pulse_clean", sw_clean, e.clean);
        check("pulse_changed", {{(W-1){1'b0}}, sw_changed}, {{(W-1){1'b0}}, 1'b1});
      end
    end
  end

  task automatic check_drained(input string name);
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL %s: %0d expected pulses never seen, next due edge %0d (now %0d)",
               name, exp_q.size(), exp_q[0].at_edge, cyc);
      exp_q.delete();
    end
  endtask

  initial begin
    reset_n = 1'b0;
    sw_raw  = 10'h3FF;

    // 1. Reset with all switches high, then power-up debounce.
    repeat (3) begin
      @(negedge clk);
      check("reset_clean", sw_clean, 10'h000);
      check("reset_mask", change_mask, 10'h000);
      check("reset_changed", {{(W-1){1'b0}}, sw_changed}, 10'h000);
    end
    reset_n = 1'b1;
    expect_change(10'h3FF, 10'h3FF);
    wait_cyc(14);
    check_drained("t1_rise");
    check("t1_clean", sw_clean, 10'h3FF);

    sw_raw = 10'h000;
    expect_change(10'h3FF, 10'h000);
    wait_cyc(14);
    check_drained("t1_fall");
    check("t1_clean_low", sw_clean, 10'h000);

    // 2. Clean step on bit 3, and back.
    sw_raw = 10'h008;
    expect_change(10'h008, 10'h008);
    wait_cyc(14);
    check_drained("t2_rise");
    check("t2_clean", sw_clean, 10'h008);
    sw_raw = 10'h000;
    expect_change(10'h008, 10'h000);
    wait_cyc(14);
    check_drained("t2_fall");

    // 3. Bounce on bit 5, 3 cycles per level: must never be accepted.
    for (int n = 0; n < 2; n++) begin
      sw_raw = 10'h020;
      wait_cyc(3);
      sw_raw = 10'h000;
      wait_cyc(3);
    end
    wait_cyc(14);
    check("t3_clean", sw_clean, 10'h000);

    // 4. Bit 0: 2 high, 1 low, then high for good.
    sw_raw = 10'h001;
    wait_cyc(2);
    sw_raw = 10'h000;
    wait_cyc(1);
    sw_raw = 10'h001;
    expect_change(10'h001, 10'h001);
    wait_cyc(14);
    check_drained("t4_settle");
    check("t4_clean", sw_clean, 10'h001);
    sw_raw = 10'h000;
    expect_change(10'h001, 10'h000);
    wait_cyc(14);
    check_drained("t4_fall");

    // 5. Bits 1 and 9 together, bit 4 three cycles later.
    sw_raw = 10'h202;
    expect_change(10'h202, 10'h202);
    wait_cyc(3);
    sw_raw = 10'h212;
    expect_change(10'h010, 10'h212);
    wait_cyc(14);
    check_drained("t5_rise");
    check("t5_clean", sw_clean, 10'h212);
    sw_raw = 10'h000;
    expect_change(10'h212, 10'h000);
    wait_cyc(14);
    check_drained("t5_fall");

    // 6. Async reset while bit 7 is pending (counter = 5) and bit 2 is settled.
    sw_raw = 10'h004;
    expect_change(10'h004, 10'h004);
    wait_cyc(14);
    check_drained("t6_pre");
    sw_raw = 10'h084;
    // Bit 7 first sampled at edge cyc+1; counter reads 5 after edge cyc+7.
    wait_cyc(7);
    #3;
    check("t6_clean_before", sw_clean, 10'h004);
    reset_n = 1'b0;
    #1;
    check("t6_async_clean", sw_clean, 10'h000);
    check("t6_async_mask", change_mask, 10'h000);
    check("t6_async_changed", {{(W-1){1'b0}}, sw_changed}, 10'h000);
    wait_cyc(2);
    reset_n = 1'b1;
    expect_change(10'h084, 10'h084);
    wait_cyc(14);
    check_drained("t6_redebounce");
    check("t6_clean", sw_clean, 10'h084);

    wait_cyc(2);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Hard stop in case the stimulus ever stalls.
  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit at edge %0d", cyc);
    $fatal(1, "timeout");
  end

endmodule
